dct_coef_streamer: RTL and testbench

Parametrised successor to the fixed 8x8 cosine-prime ROM. On a start pulse it streams the N_POINT coefficient vectors of the scaled DCT matrix, one per valid/ready handshake. Vectors are rows of C (forward) or columns of C (transposed/inverse). It feeds the 1-D DCT/IDCT MAC array, and its backpressure lets the array stall.

---
 rtl/dct_coef_pkg.sv | 57 +++++
 rtl/dct_coef_table.sv | 39 +++
 rtl/dct_coef_streamer.sv | 142 ++++++++++++++
 tb/tb_dct_coef_streamer.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dct_coef_pkg.sv
// ---------------------------------------------------------------------------
// dct_coef_pkg
// Shared definitions for the DCT coefficient streamer:
//   - C8_TABLE : 64-entry scaled 8-point DCT matrix, row-major,
//                C[k][n] = floor(2048*a(k)*cos((2n+1)k*pi/16)),
//                a(0)=1/sqrt2, a(k>0)=1
//   - state_t  : streamer FSM encoding (IDLE=0, STREAM=1)
//   - coef()   : table lookup that folds the 4-point transform onto the
//                even rows of the 8-point table (C4[k][n] = C8[2k][n])
// ---------------------------------------------------------------------------
package dct_coef_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  localparam logic signed [12:0] C8_TABLE [64] = '{
    // k = 0
    13'sd1448,  13'sd1448,  13'sd1448,  13'sd1448,
    13'sd1448,  13'sd1448,  13'sd1448,  13'sd1448,
    // k = 1
    13'sd2008,  13'sd1702,  13'sd1137,  13'sd399,
    -13'sd400,  -13'sd1138, -13'sd1703, -13'sd2009,
    // k = 2
    13'sd1892,  13'sd783,   -13'sd784,  -13'sd1893,
    -13'sd1893, -13'sd784,  13'sd783,   13'sd1892,
    // k = 3
    13'sd1702,  -13'sd400,  -13'sd2009, -13'sd1138,
    13'sd1137,  13'sd2008,  13'sd399,   -13'sd1703,
    // k = 4
    13'sd1448,  -13'sd1449, -13'sd1449, 13'sd1448,
    13'sd1448,  -13'sd1449, -13'sd1449, 13'sd1448,
    // k = 5
    13'sd1137,  -13'sd2009, 13'sd399,   13'sd1702,
    -13'sd1703, -13'sd400,  13'sd2008,  -13'sd1138,
    // k = 6
    13'sd783,   -13'sd1893, 13'sd1892,  -13'sd784,
    -13'sd784,  13'sd1892,  -13'sd1893, 13'sd783,
    // k = 7
    13'sd399,   -13'sd1138, 13'sd1702,  -13'sd2009,
    13'sd2008,  -13'sd1703, 13'sd1137,  -13'sd400
  };

  // The 4-point matrix reuses the even rows of the 8-point one, so only the
  // row address is remapped; the column index is used as-is.
  function automatic logic signed [12:0] coef(input logic [2:0] k,
                                              input logic [2:0] n,
                                              input int         npoint);
    logic [2:0] row;
    logic [5:0] addr;
    row  = (npoint == 4) ? {k[1:0], 1'b0} : k;
    addr = {row, n};
    return C8_TABLE[addr];
  endfunction

endpackage

// File: rtl/dct_coef_table.sv
// ---------------------------------------------------------------------------
// dct_coef_table
// Combinational lookup of one coefficient vector of the scaled DCT matrix.
// Parameters: N_POINT (4 or 8), COEF_W (>=13), IDX_W (index width)
// Ports:
//   index     : row (transpose=0) or column (transpose=1) to fetch
//   transpose : 0 = row of C, 1 = column of C
//   vec       : packed vector, element 0 in the MSBs, each element
//               sign-extended from 13 bits to COEF_W
// ---------------------------------------------------------------------------
module dct_coef_table
  import dct_coef_pkg::*;
#(
  parameter int N_POINT = 8,
  parameter int COEF_W  = 13,
  parameter int IDX_W   = 3
) (
  input  logic [IDX_W-1:0]          index,
  input  logic                      transpose,
  output logic [N_POINT*COEF_W-1:0] vec
);

  logic [2:0] idx3;

  assign idx3 = 3'(index);

  // Walk the vector elements; transpose simply swaps which of (k, n) comes
  // from the requested index and which from the element position.
  always_comb begin
    vec = '0;
    for (int e = 0; e < N_POINT; e++) begin
      vec[(N_POINT-1-e)*COEF_W +: COEF_W] =
        COEF_W'(coef(transpose ? 3'(e) : idx3,
                     transpose ? idx3  : 3'(e),
                     N_POINT));
    end
  end

endmodule

// File: rtl/dct_coef_streamer.sv
// ---------------------------------------------------------------------------
// dct_coef_streamer
// Streams the N_POINT coefficient vectors of the scaled DCT matrix (rows of C,
// or columns of C when transposed) over a valid/ready handshake, one vector
// per accepted transfer, after a start pulse.
// Parameters: N_POINT (4 or 8), COEF_W (>=13), IDX_W (>= clog2(N_POINT))
// Ports:
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   i_start      : begins a stream; only honoured while idle
//   i_transpose  : 0 = rows, 1 = columns; captured when start is accepted
//   i_ready      : consumer ready
//   o_valid      : vector valid
//   o_last       : final vector of the stream
//   o_index      : row/column index of the current vector
//   o_data       : packed vector, element 0 in the MSBs
//   o_busy       : from start acceptance until the last handshake
//   o_parity     : XOR of o_data (only with DCT_COEF_PARITY_EN defined)
// Optional feature macro: DCT_COEF_PARITY_EN
// ---------------------------------------------------------------------------
module dct_coef_streamer #(
  parameter int N_POINT = 8,
  parameter int COEF_W  = 13,
  parameter int IDX_W   = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      i_start,
  input  logic                      i_transpose,
  input  logic                      i_ready,
  output logic                      o_valid,
  output logic                      o_last,
  output logic [IDX_W-1:0]          o_index,
  output logic [N_POINT*COEF_W-1:0] o_data,
  output logic                      o_busy
`ifdef DCT_COEF_PARITY_EN
  ,
  output logic                      o_parity
`endif
);

  import dct_coef_pkg::*;

  // Reject unsupported configurations at elaboration time.
  if (!(N_POINT == 4 || N_POINT == 8)) begin : g_bad_npoint
    $error("dct_coef_streamer: N_POINT must be 4 or 8");
  end
  if (COEF_W < 13) begin : g_bad_coefw
    $error("dct_coef_streamer: COEF_W must be at least 13");
  end
  if (IDX_W < $clog2(N_POINT)) begin : g_bad_idxw
    $error("dct_coef_streamer: IDX_W too small for N_POINT");
  end

  localparam logic [IDX_W-1:0] LAST_INDEX = IDX_W'(N_POINT - 1);

  state_t                      state;
  logic                        transpose_q;
  logic                        handshake;
  logic [IDX_W-1:0]            lookup_index;
  logic                        lookup_transpose;
  logic [N_POINT*COEF_W-1:0]   lookup_vec;

  assign handshake = o_valid & i_ready;

  // The table always looks up the vector that would be loaded on the next
  // edge: vector 0 with the live transpose input while idle, otherwise the
  // following index with the captured transpose. i_ready only gates the
  // register load, so it never reaches o_data combinationally.
  always_comb begin
    lookup_index     = '0;
    lookup_transpose = i_transpose;
    if (state == STREAM) begin
      lookup_index     = o_index + IDX_W'(1);
      lookup_transpose = transpose_q;
    end
  end

  dct_coef_table #(
    .N_POINT (N_POINT),
    .COEF_W  (COEF_W),
    .IDX_W   (IDX_W)
  ) u_table (
    .index     (lookup_index),
    .transpose (lookup_transpose),
    .vec       (lookup_vec)
  );

  // Streamer FSM with all outputs registered. Start is only looked at in
  // IDLE, so a start coinciding with the last handshake is dropped and a
  // restart lands no earlier than the cycle after o_busy falls. On the final
  // handshake o_index/o_data keep their last values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      transpose_q <= 1'b0;
      o_valid     <= 1'b0;
      o_last      <= 1'b0;
      o_busy      <= 1'b0;
      o_index     <= '0;
      o_data      <= '0;
`ifdef DCT_COEF_PARITY_EN
      o_parity    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            state       <= STREAM;
            transpose_q <= i_transpose;
            o_valid     <= 1'b1;
            o_busy      <= 1'b1;
            o_last      <= 1'b0;
            o_index     <= '0;
            o_data      <= lookup_vec;
`ifdef DCT_COEF_PARITY_EN
            o_parity    <= ^lookup_vec;
`endif
          end
        end
        STREAM: begin
          if (handshake) begin
            if (o_last) begin
              state   <= IDLE;
              o_valid <= 1'b0;
              o_busy  <= 1'b0;
              o_last  <= 1'b0;
            end else begin
              o_index  <= lookup_index;
              o_data   <= lookup_vec;
              o_last   <= (lookup_index == LAST_INDEX);
`ifdef DCT_COEF_PARITY_EN
              o_parity <= ^lookup_vec;
`endif
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dct_coef_streamer.sv
// ---------------------------------------------------------------------------
// tb_dct_coef_streamer
// Self-checking bench for dct_coef_streamer. Three instances cover
// N_POINT=8/COEF_W=13, N_POINT=4/COEF_W=13 and N_POINT=8/COEF_W=16; one is
// selected at a time. Expected vectors come from a real-valued cosine model
// and are queued when a start is driven, then popped on each handshake.
// ---------------------------------------------------------------------------
module tb_dct_coef_streamer;

  localparam real PI = 3.14159265358979323846;

  logic clock;
  logic reset;
  logic start;
  logic tr;
  logic ready;
  int   sel;

  logic start_a, start_b, start_c;

  logic             valid_a, last_a, busy_a;
  logic [2:0]       index_a;
  logic [8*13-1:0]  data_a;
  logic             valid_b, last_b, busy_b;
  logic [2:0]       index_b;
  logic [4*13-1:0]  data_b;
  logic             valid_c, last_c, busy_c;
  logic [2:0]       index_c;
  logic [8*16-1:0]  data_c;
`ifdef DCT_COEF_PARITY_EN
  logic             parity_a, parity_b, parity_c, mon_parity;
`endif

  logic             mon_valid, mon_last, mon_busy;
  logic [2:0]       mon_index;
  logic [127:0]     mon_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]   idx;
    logic [127:0] data;
    logic         last;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    int sel;
    bit tr;
    int idx;
    int slot;
    int value;
  } spot_t;

  spot_t spots[13];

  assign start_a = (sel == 0) ? start : 1'b0;
  assign start_b = (sel == 1) ? start : 1'b0;
  assign start_c = (sel == 2) ? start : 1'b0;

  dct_coef_streamer #(.N_POINT(8), .COEF_W(13), .IDX_W(3)) dut_a (
    .clock(clock), .reset(reset), .i_start(start_a), .i_transpose(tr),
    .i_ready(ready), .o_valid(valid_a), .o_last(last_a), .o_index(index_a),
    .o_data(data_a), .o_busy(busy_a)
`ifdef DCT_COEF_PARITY_EN
    , .o_parity(parity_a)
`endif
  );

  dct_coef_streamer #(.N_POINT(4), .COEF_W(13), .IDX_W(3)) dut_b (
    .clock(clock), .reset(reset), .i_start(start_b), .i_transpose(tr),
    .i_ready(ready), .o_valid(valid_b), .o_last(last_b), .o_index(index_b),
    .o_data(data_b), .o_busy(busy_b)
`ifdef DCT_COEF_PARITY_EN
    , .o_parity(parity_b)
`endif
  );

  dct_coef_streamer #(.N_POINT(8), .COEF_W(16), .IDX_W(3)) dut_c (
    .clock(clock), .reset(reset), .i_start(start_c), .i_transpose(tr),
    .i_ready(ready), .o_valid(valid_c), .o_last(last_c), .o_index(index_c),
    .o_data(data_c), .o_busy(busy_c)
`ifdef DCT_COEF_PARITY_EN
    , .o_parity(parity_c)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Present the selected instance on one set of monitor signals.
  always_comb begin
    mon_valid = valid_a;
    mon_last  = last_a;
    mon_busy  = busy_a;
    mon_index = index_a;
    mon_data  = 128'(data_a);
`ifdef DCT_COEF_PARITY_EN
    mon_parity = parity_a;
`endif
    case (sel)
      1: begin
        mon_valid = valid_b;
        mon_last  = last_b;
        mon_busy  = busy_b;
        mon_index = index_b;
        mon_data  = 128'(data_b);
`ifdef DCT_COEF_PARITY_EN
        mon_parity = parity_b;
`endif
      end
      2: begin
        mon_valid = valid_c;
        mon_last  = last_c;
        mon_busy  = busy_c;
        mon_index = index_c;
        mon_data  = data_c;
`ifdef DCT_COEF_PARITY_EN
        mon_parity = parity_c;
`endif
      end
      default: ;
    endcase
  end

  function automatic int np_of(int s);
    return (s == 1) ? 4 : 8;
  endfunction

  function automatic int w_of(int s);
    return (s == 2) ? 16 : 13;
  endfunction

  function automatic int c8(int k, int n);
    real a;
    a = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
    return int'($floor(2048.0 * a * $cos(real'((2 * n + 1) * k) * PI / 16.0)));
  endfunction

  function automatic logic [127:0] mask_of(int w);
    return (128'd1 << w) - 128'd1;
  endfunction

  function automatic logic [127:0] model_vec(int np, int w, int idx, bit trv);
    logic [127:0] v;
    int k, n;
    v = '0;
    for (int e = 0; e < np; e++) begin
      k = trv ? e : idx;
      n = trv ? idx : e;
      if (np == 4) k = 2 * k;
      v = (v << w) | (128'(c8(k, n)) & mask_of(w));
    end
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [135:0] act,
                             input logic [135:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_stream(input bit trv);
    int np, w;
    exp_t r;
    np = np_of(sel);
    w  = w_of(sel);
    for (int i = 0; i < np; i++) begin
      r.idx  = 3'(i);
      r.data = model_vec(np, w, i, trv);
      r.last = (i == np - 1);
      sb.push_back(r);
    end
  endtask

  // Drive a start pulse on the selected instance, queue its expected stream,
  // then flip transpose so a mid-stream change would be visible.
  task automatic applyStimulus(input bit trv);
    @(posedge clock); #1;
    start = 1'b1;
    tr    = trv;
    push_stream(trv);
    @(posedge clock); #1;
    start = 1'b0;
    tr    = ~trv;
    checkOutput("start_latency", 136'({mon_valid, mon_busy, mon_index}),
                136'({1'b1, 1'b1, 3'd0}));
  endtask

  task automatic wait_index(input int idx);
    int n;
    n = 0;
    @(negedge clock);
    while (!(mon_valid && mon_index == 3'(idx)) && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) checkOutput("wait_index_timeout", 136'(n), 136'(0));
  endtask

  task automatic wait_posedge_index(input int idx);
    int n;
    n = 0;
    while (!(mon_valid && mon_index == 3'(idx)) && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    if (n >= 200) checkOutput("wait_index_timeout", 136'(n), 136'(0));
  endtask

  task automatic wait_idle(input bit rnd);
    int n;
    n = 0;
    while (mon_busy && n < 500) begin
      @(posedge clock); #1;
      if (rnd) ready = ($urandom_range(0, 1) == 1);
      n++;
    end
    if (n >= 500) checkOutput("wait_idle_timeout", 136'(n), 136'(0));
    ready = 1'b1;
    @(posedge clock); #1;
  endtask

  // Scoreboard and stall monitor, sampled on the falling edge so values are
  // stable before the rising edge that would complete a handshake.
  logic         held_valid = 1'b0;
  logic         held_last;
  logic [2:0]   held_index;
  logic [127:0] held_data;

  always @(negedge clock) begin
    exp_t r;
    if (reset) begin
      held_valid = 1'b0;
    end else begin
      if (held_valid) begin
        checkOutput("stall_hold_ctl", 136'({mon_valid, mon_last, mon_index}),
                    136'({1'b1, held_last, held_index}));
        checkOutput("stall_hold_data", 136'(mon_data), 136'(held_data));
      end
      held_valid = mon_valid && !ready;
      held_last  = mon_last;
      held_index = mon_index;
      held_data  = mon_data;
`ifdef DCT_COEF_PARITY_EN
      if (mon_valid) checkOutput("parity", 136'(mon_parity), 136'(^mon_data));
`endif
      if (mon_valid && ready) begin
        if (sb.size() == 0) begin
          checkOutput("sb_extra_vector", 136'({mon_last, mon_index}), 136'(0));
        end else begin
          r = sb.pop_front();
          checkOutput("sb_index_last", 136'({mon_busy, mon_last, mon_index}),
                      136'({1'b1, r.last, r.idx}));
          checkOutput("sb_data", 136'(mon_data), 136'(r.data));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int n;
    logic [127:0] slot_val;

    spots[0]  = '{0, 1'b0, 0, 0, 1448};
    spots[1]  = '{0, 1'b0, 0, 7, 1448};
    spots[2]  = '{0, 1'b0, 1, 0, 2008};
    spots[3]  = '{0, 1'b0, 1, 3, 399};
    spots[4]  = '{0, 1'b0, 1, 4, -400};
    spots[5]  = '{0, 1'b0, 1, 7, -2009};
    spots[6]  = '{0, 1'b1, 0, 2, 1892};
    spots[7]  = '{0, 1'b1, 0, 7, 399};
    spots[8]  = '{1, 1'b0, 1, 0, 1892};
    spots[9]  = '{1, 1'b0, 1, 3, -1893};
    spots[10] = '{1, 1'b0, 3, 1, -1893};
    spots[11] = '{2, 1'b0, 1, 7, 32'h0000F827};
    spots[12] = '{2, 1'b1, 0, 1, 2008};

    sel   = 0;
    start = 1'b0;
    tr    = 1'b0;
    ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checkOutput("reset_state", 136'({mon_valid, mon_last, mon_busy, mon_index}),
                136'(0));
    checkOutput("reset_data", 136'(mon_data), 136'(0));
    @(posedge clock); #1;
    reset = 1'b0;
    ready = 1'b1;

    // Spot values of specific vector elements across all three instances.
    for (int i = 0; i < 13; i++) begin
      sel   = spots[i].sel;
      ready = 1'b1;
      applyStimulus(spots[i].tr);
      wait_index(spots[i].idx);
      slot_val = (mon_data >> ((np_of(sel) - 1 - spots[i].slot) * w_of(sel)))
                 & mask_of(w_of(sel));
      checkOutput($sformatf("spot%0d", i), 136'(slot_val),
                  136'(128'(spots[i].value) & mask_of(w_of(sel))));
      wait_idle(1'b0);
    end

    // With ready held high a stream occupies exactly N cycles.
    sel = 0;
    applyStimulus(1'b0);
    n = 0;
    while (mon_busy && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    checkOutput("busy_length_n8", 136'(n), 136'(8));
    @(posedge clock); #1;

    sel = 1;
    applyStimulus(1'b1);
    n = 0;
    while (mon_busy && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    checkOutput("busy_length_n4", 136'(n), 136'(4));
    @(posedge clock); #1;

    // Stalls at the first and the last vector.
    sel   = 0;
    ready = 1'b0;
    applyStimulus(1'b0);
    repeat (3) @(posedge clock);
    #1;
    checkOutput("stall_first", 136'({mon_valid, mon_index}), 136'({1'b1, 3'd0}));
    ready = 1'b1;
    wait_posedge_index(7);
    ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("stall_last", 136'({mon_valid, mon_last, mon_busy, mon_index}),
                136'({1'b1, 1'b1, 1'b1, 3'd7}));
    ready = 1'b1;
    wait_idle(1'b0);

    // Start pulses during a stream and on the last-handshake cycle are
    // ignored; holding start one more cycle restarts cleanly.
    sel = 0;
    applyStimulus(1'b0);
    repeat (2) @(posedge clock);
    #1;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    wait_posedge_index(7);
    start = 1'b1;
    tr    = 1'b1;
    push_stream(1'b1);
    @(posedge clock); #1;
    checkOutput("start_on_last_ignored", 136'({mon_valid, mon_busy}), 136'(0));
    @(posedge clock); #1;
    start = 1'b0;
    tr    = 1'b0;
    checkOutput("restart_after_busy", 136'({mon_valid, mon_busy, mon_index}),
                136'({1'b1, 1'b1, 3'd0}));
    wait_idle(1'b0);

    // Random backpressure across all configurations.
    for (int r = 0; r < 9; r++) begin
      sel = r % 3;
      applyStimulus(r[0]);
      wait_idle(1'b1);
    end

    // Asynchronous reset in the middle of a stream.
    sel   = 0;
    ready = 1'b1;
    applyStimulus(1'b0);
    wait_posedge_index(4);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_state",
                136'({mon_valid, mon_last, mon_busy, mon_index}), 136'(0));
    checkOutput("async_reset_data", 136'(mon_data), 136'(0));
    sb.delete();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    checkOutput("post_reset_idle", 136'({mon_valid, mon_busy}), 136'(0));
    applyStimulus(1'b1);
    wait_idle(1'b0);

    checkOutput("sb_drained", 136'(sb.size()), 136'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
